// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit (8 ops) with valid/ready handshake and an accumulate-burst mode.
// Define LOGIC_UNIT_FLAGS_EN to register the out_zero/out_parity flags; otherwise they are tied to 0.
module logic_unit_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_acc,
    input  logic             in_last,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             accept;
    logic             pop;
    logic             load;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] beat_result;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    // Inside a burst the running accumulator replaces in_x as the left operand.
    assign operand_a   = (state_q == ST_ACCUM) ? acc_q : in_x;
    assign beat_result = logic_op(in_op, operand_a, in_y);

    // Flush wins over any beat accepted in the same cycle; the beat is dropped.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        load    = 1'b0;
        if (in_flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                if (in_acc && !in_last) begin
                    acc_d   = beat_result;
                    state_d = ST_ACCUM;
                end else begin
                    load = 1'b1;
                end
            end else begin
                if (in_last) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = beat_result;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_result;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic zero_q, zero_d;
    logic parity_q, parity_d;

    always_comb begin
        zero_d   = zero_q;
        parity_d = parity_q;
        if (load) begin
            zero_d   = (beat_result == '0);
            parity_d = ^beat_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign out_zero   = zero_q;
    assign out_parity = parity_q;
`else
    assign out_zero   = 1'b0;
    assign out_parity = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed vector table, hand-written corner sequences,
// then randomized traffic against a truth-table reference model.
module tb_logic_unit_pipe;

    localparam int WIDTH = 16;
`ifdef LOGIC_UNIT_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_acc;
    logic             in_last;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_parity;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: pending result register and burst accumulator.
    logic             m_ov;
    logic [WIDTH-1:0] m_od;
    logic             m_zero;
    logic             m_par;
    logic             m_accum;
    logic [WIDTH-1:0] m_acc;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] expData;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_acc     (in_acc),
        .in_last    (in_last),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .busy       (busy)
    );

    // Each op is a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] refOp(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0100;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("out_valid", out_valid, m_ov);
        checkOutput("out_data", out_data, m_od);
        checkOutput("busy", busy, m_accum);
        checkOutput("out_zero", out_zero, m_zero);
        checkOutput("out_parity", out_parity, m_par);
    endtask

    task automatic modelReset();
        m_ov    = 1'b0;
        m_od    = '0;
        m_zero  = 1'b0;
        m_par   = 1'b0;
        m_accum = 1'b0;
        m_acc   = '0;
    endtask

    task automatic driveIdle();
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_x      = '0;
        in_y      = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
    endtask

    // One clock cycle: drive, check in_ready, advance model, clock, compare everything.
    task automatic applyStimulus(input logic iv, input logic [2:0] op,
                                 input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic acc, input logic last, input logic flush,
                                 input logic ordy);
        logic             expReady;
        logic             emit;
        logic [WIDTH-1:0] r;
        logic             nOv, nZero, nPar, nAccum;
        logic [WIDTH-1:0] nOd, nAcc;
        in_valid  = iv;
        in_op     = op;
        in_x      = x;
        in_y      = y;
        in_acc    = acc;
        in_last   = last;
        in_flush  = flush;
        out_ready = ordy;
        #1;
        expReady = !m_ov || ordy;
        checkOutput("in_ready", in_ready, expReady);
        emit = 1'b0;
        r = '0;
        nOv = m_ov; nOd = m_od; nZero = m_zero; nPar = m_par;
        nAccum = m_accum; nAcc = m_acc;
        if (m_ov && ordy) nOv = 1'b0;
        if (flush) begin
            nAccum = 1'b0;
            nAcc   = '0;
        end else if (iv && expReady) begin
            if (!m_accum) begin
                r = refOp(op, x, y);
                if (acc && !last) begin
                    nAcc   = r;
                    nAccum = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end else begin
                r = refOp(op, m_acc, y);
                if (last) begin
                    emit   = 1'b1;
                    nAcc   = '0;
                    nAccum = 1'b0;
                end else begin
                    nAcc = r;
                end
            end
        end
        if (emit) begin
            nOv   = 1'b1;
            nOd   = r;
            nZero = FLAGS && (r == '0);
            nPar  = FLAGS && (^r);
        end
        @(posedge clk);
        #1;
        m_ov = nOv; m_od = nOd; m_zero = nZero; m_par = nPar;
        m_accum = nAccum; m_acc = nAcc;
        checkModel();
    endtask

    task automatic asyncReset(input string tag);
        driveIdle();
        #3;
        rst_n = 1'b0;
        #2;
        modelReset();
        checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
        checkOutput({tag, "_out_data"}, out_data, 16'h0000);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[1] = '{3'd1, 16'hF0F0, 16'hFF00, 16'hFFF0};
        vecs[2] = '{3'd2, 16'hF0F0, 16'hFF00, 16'h0FF0};
        vecs[3] = '{3'd3, 16'hF0F0, 16'hFF00, 16'h0FFF};
        vecs[4] = '{3'd4, 16'hF0F0, 16'hFF00, 16'h000F};
        vecs[5] = '{3'd5, 16'hF0F0, 16'hFF00, 16'hF00F};
        vecs[6] = '{3'd6, 16'hF0F0, 16'hFF00, 16'h00F0};
        vecs[7] = '{3'd7, 16'hF0F0, 16'hFF00, 16'hF0F0};

        driveIdle();
        modelReset();
        rst_n = 1'b0;
        #12;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_data", out_data, 16'h0000);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_out_zero", out_zero, 1'b0);
        checkOutput("reset_out_parity", out_parity, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] all eight ops back-to-back");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].x, vecs[i].y, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("op%0d_valid", i), out_valid, 1'b1);
            checkOutput($sformatf("op%0d_data", i), out_data, vecs[i].expData);
        end
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_valid", out_valid, 1'b0);

        $display("[TB] stall and release");
        applyStimulus(1'b1, 3'd1, 16'h00F0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stall_first", out_data, 16'h00FF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'd2, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("stall_in_ready", in_ready, 1'b0);
            checkOutput("stall_hold", out_data, 16'h00FF);
        end
        applyStimulus(1'b1, 3'd2, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("release_data", out_data, 16'h0000);
        checkOutput("release_zero", out_zero, FLAGS);
        checkOutput("release_parity", out_parity, 1'b0);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] OR-reduce burst");
        applyStimulus(1'b1, 3'd1, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("burst_b1_busy", busy, 1'b1);
        checkOutput("burst_b1_valid", out_valid, 1'b0);
        applyStimulus(1'b1, 3'd1, 16'hAAAA, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("burst_b2_busy", busy, 1'b1);
        checkOutput("burst_b2_valid", out_valid, 1'b0);
        applyStimulus(1'b1, 3'd1, 16'h5555, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("burst_busy_end", busy, 1'b0);
        checkOutput("burst_valid", out_valid, 1'b1);
        checkOutput("burst_data", out_data, 16'h8013);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] flush mid-burst");
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_busy_pre", busy, 1'b1);
        applyStimulus(1'b1, 3'd1, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_busy", busy, 1'b0);
        checkOutput("flush_no_output", out_valid, 1'b0);
        applyStimulus(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_flush_data", out_data, 16'h0FF0);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] asynchronous reset");
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_valid", out_valid, 1'b1);
        asyncReset("rst_pending");
        applyStimulus(1'b1, 3'd1, 16'h0F00, 16'h00F0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset_busy", busy, 1'b1);
        asyncReset("rst_burst");
        applyStimulus(1'b1, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("nor_single_data", out_data, 16'hFFFF);
        checkOutput("nor_single_parity", out_parity, 1'b0);
        checkOutput("nor_single_zero", out_zero, 1'b0);
        checkOutput("nor_single_busy", busy, 1'b0);
        applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            logic [WIDTH-1:0] rx, ry;
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) ry = '0;
            if ($urandom_range(0, 7) == 0) ry = '1;
            applyStimulus($urandom_range(0, 3) != 0,
                          3'($urandom_range(0, 7)),
                          rx, ry,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit. It is the successor to the fixed 16-bit OR array and serves as the ALU logic slice of the datapath. It supports eight bitwise ops on WIDTH-bit operands, with valid/ready handshaking on input and output. An accumulate mode folds a multi-beat burst into one result; for example, an OR-reduce of a word stream.

Parameters:
WIDTH, 16, operand/result width in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_op  input  3  op select (encoding below)
in_x  input  WIDTH  operand X (ignored on non-first accumulate beats)
in_y  input  WIDTH  operand Y
in_acc  input  1  beat starts/belongs to accumulate burst (sampled only in IDLE)
in_last  input  1  final beat of accumulate burst
in_flush  input  1  synchronous abort of accumulate burst
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_zero  output  1  out_data == 0 (see optional feature)
out_parity  output  1  XOR-reduce of out_data (see optional feature)
busy  output  1  accumulate burst in progress (state ACCUM)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_zero=0, out_parity=0, busy=0, accumulator=0, state=IDLE.
- Op encoding f(a,b):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 ANDN: a & ~b.
  - 7 PASS: a.
  - All ops are bitwise over WIDTH; no carries; result width is exactly WIDTH.
- Handshake:
  - in_ready = !out_valid | out_ready, combinational and identical in both states.
  - accept = in_valid & in_ready.
  - Output pops when out_valid & out_ready.
  - out_data and the flags are held stable while out_valid & !out_ready.
- Output register update:
  - Pop and load in the same cycle: out_valid stays 1 and new data is loaded, giving one result per cycle at full throughput.
  - Pop with no load: out_valid goes to 0.
- FSM with states IDLE and ACCUM.
- IDLE, accept with in_acc=0:
  - out_data <= f(in_x,in_y), out_valid=1 next cycle. Latency 1 cycle.
  - in_last is ignored.
- IDLE, accept with in_acc=1 and in_last=1: single-beat burst, treated exactly like in_acc=0.
- IDLE, accept with in_acc=1 and in_last=0:
  - acc <= f(in_x,in_y); go to ACCUM.
  - No output is produced.
- ACCUM, accept with in_last=0:
  - acc <= f(acc,in_y) using that beat's in_op; in_x is ignored.
  - No output is produced.
- ACCUM, accept with in_last=1:
  - out_data <= f(acc,in_y), out_valid=1 next cycle.
  - acc <= 0; go to IDLE.
- in_acc is ignored in ACCUM; a burst ends only on in_last or in_flush.
- in_flush=1, any state:
  - state <= IDLE, acc <= 0.
  - Any beat accepted in the same cycle is discarded: no acc update and no output.
  - A pending out_valid result is unaffected and still delivered.
- busy = (state == ACCUM), registered.
- No combinational path from in_* to out_data or out_valid. The only combinational path is out_ready -> in_ready.

Optional Feature:
Macro: LOGIC_UNIT_FLAGS_EN
- Defined:
  - out_zero and out_parity are registered alongside out_data, computed from the value being loaded.
  - They are held under stall and reset to 0.
- Undefined: out_zero and out_parity are tied to 0 and no flag logic is synthesised. The ports remain present.

Test Plan:
1. WIDTH=16, no stall. Ops 0-7 with x=16'hF0F0, y=16'hFF00:
   - Expect 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'h00F0, 16'hF0F0.
   - Each result appears one cycle after accept; back-to-back beats give out_valid high for 8 consecutive cycles.
2. Stall: out_ready=0 for 3 cycles after an OR result 16'h00FF.
   - in_ready=0 during the stall; out_data stays 16'h00FF.
   - A held in_valid beat (op XOR, 16'h1234 ^ 16'h1234) is accepted on the release cycle; next result is 16'h0000, with out_zero=1 when flags are enabled.
3. OR-reduce burst, op=1, in_acc=1:
   - Beats are (x=16'h0001, y=16'h0002), then y=16'h0010, then y=16'h8000 with in_last.
   - Single output 16'h8013; busy high from the cycle after beat 1 until the cycle after the last beat.
4. Flush: start an AND burst (x=16'hFFFF, y=16'h0F0F), then assert in_flush together with a valid beat.
   - No output; busy returns to 0.
   - The next plain beat, XOR 16'h00FF/16'h0F0F, yields 16'h0FF0.
5. Reset: assert rst_n=0 asynchronously mid-burst with out_valid=1.
   - Immediately out_valid=0, out_data=0, busy=0.
   - After release, a single-beat burst (in_acc=1, in_last=1, NOR 0/0) yields 16'hFFFF with out_parity=0.
6. Flags macro undefined: repeat scenario 2. Data is identical; out_zero and out_parity stay 0 throughout.
